bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
- Sits downstream of the Fibonacci memory sequencer. It takes the 16-bit value latched for display and produces packed decimal digits for the seven-segment scan driver.
- Start/done handshake. Last result is held stable between conversions.

---
 rtl/bin_to_bcd_seq_pkg.sv | 12 +
 rtl/bin_to_bcd_seq_if.sv | 22 ++
 rtl/bin_to_bcd_seq_add3_cell.sv | 10 +
 rtl/bin_to_bcd_seq.sv | 123 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: state
// encoding, digit width and the add-3 threshold.
package bcd_pkg;
  localparam int         DIGIT_W     = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    FINISH = 2'd2
  } state_e;
endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/done handshake and result bus of bin_to_bcd_seq.
// Carries the optional blank vector when BCD_BLANK_LEADING_EN is defined.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) ();
  logic                  start;
  logic [WIDTH-1:0]      binary_in;
  logic                  busy;
  logic                  done;
  logic [DIGITS*4-1:0]   bcd_out;
  logic                  over_range;
`ifdef BCD_BLANK_LEADING_EN
  logic [DIGITS-1:0]     blank;

  modport master (output start, binary_in, input busy, done, bcd_out, over_range, blank);
  modport slave  (input start, binary_in, output busy, done, bcd_out, over_range, blank);
`else
  modport master (output start, binary_in, input busy, done, bcd_out, over_range);
  modport slave  (input start, binary_in, output busy, done, bcd_out, over_range);
`endif
endinterface

// File: rtl/bin_to_bcd_seq_add3_cell.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
module bcd_add3_cell
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);
  assign digit_o = (digit_i >= ADD3_THRESH) ? digit_i + DIGIT_W'(3) : digit_i;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blank output enabled by BCD_BLANK_LEADING_EN.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int SHOWN  = 4
) (
  input  logic             clk,
  input  logic             reset,
  bin_to_bcd_seq_if.slave  bus
);
  localparam int BCD_W = DIGITS * DIGIT_W;
  localparam int TOT_W = BCD_W + WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [TOT_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovr_q, ovr_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_field;
  logic [BCD_W-1:0]   bcd_adj;
  logic               ovr_calc;

  assign bcd_field = sr_q[TOT_W-1:WIDTH];

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_add3_cell u_cell (
      .digit_i (bcd_field[g*DIGIT_W +: DIGIT_W]),
      .digit_o (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    ovr_calc = 1'b0;
    for (int i = SHOWN; i < DIGITS; i++) ovr_calc = ovr_calc | (|bcd_field[i*DIGIT_W +: DIGIT_W]);
  end

`ifdef BCD_BLANK_LEADING_EN
  logic [DIGITS-1:0] blank_q, blank_d, blank_calc;
  logic              blk_seen;

  // Scan from the top digit down; a digit is blank until a nonzero one appears.
  always_comb begin
    blk_seen   = 1'b0;
    blank_calc = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      blk_seen      = blk_seen | (|bcd_field[i*DIGIT_W +: DIGIT_W]);
      blank_calc[i] = ~blk_seen;
    end
  end
  assign bus.blank = blank_q;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovr_d   = ovr_q;
    done_d  = 1'b0;
`ifdef BCD_BLANK_LEADING_EN
    blank_d = blank_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d    = {{BCD_W{1'b0}}, bus.binary_in};
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        // Corrected digits and remaining binary bits shift left as one register.
        sr_d  = {bcd_adj[BCD_W-2:0], sr_q[WIDTH-1:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FINISH;
      end
      FINISH: begin
        bcd_d   = bcd_field;
        ovr_d   = ovr_calc;
        done_d  = 1'b1;
`ifdef BCD_BLANK_LEADING_EN
        blank_d = blank_calc;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovr_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef BCD_BLANK_LEADING_EN
      blank_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovr_q   <= ovr_d;
      done_q  <= done_d;
`ifdef BCD_BLANK_LEADING_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.bcd_out    = bcd_q;
  assign bus.over_range = ovr_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: vector table, random values against
// an arithmetic decimal model, and hand-written busy/back-to-back/reset sequences.
module tb_bin_to_bcd_seq;
  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
  localparam int SHOWN  = 4;
  localparam int LAT    = WIDTH + 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SHOWN(SHOWN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [DIGITS*4-1:0] prev_bcd = '0;

  typedef struct {
    logic [WIDTH-1:0]    v;
    logic [DIGITS*4-1:0] bcd;
    logic                ovr;
    logic [DIGITS-1:0]   blk;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned pow10(input int n);
    int unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [DIGITS*4-1:0] ref_bcd(input int unsigned v);
    logic [DIGITS*4-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic ref_ovr(input int unsigned v);
    return v >= pow10(SHOWN);
  endfunction

  // Digit i (i>=1) is blank exactly when the value has fewer than i+1 decimal digits.
  function automatic logic [DIGITS-1:0] ref_blank(input int unsigned v);
    logic [DIGITS-1:0] b = '0;
    for (int i = 1; i < DIGITS; i++) b[i] = (v < pow10(i));
    return b;
  endfunction

  // Starts a conversion on the next falling edge and returns at the falling
  // edge of the done cycle; lat counts clocks from the accepting edge.
  task automatic convert(input logic [WIDTH-1:0] v, output int lat);
    bit got = 0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.binary_in = v;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_in_conv", 32'(bus.busy), 32'd1);
    chk("hold_while_busy", 32'(bus.bcd_out), 32'(prev_bcd));
    for (int k = 0; k < 40 && !got; k++) begin
      if (bus.done) got = 1;
      else begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_check(input string name, input logic [WIDTH-1:0] v,
                           input logic [DIGITS*4-1:0] eb, input logic eo,
                           input logic [DIGITS-1:0] ek);
    int lat;
    convert(v, lat);
    chk({name, "_lat"}, 32'(lat), 32'(LAT));
    chk({name, "_bcd"}, 32'(bus.bcd_out), 32'(eb));
    chk({name, "_ovr"}, 32'(bus.over_range), 32'(eo));
`ifdef BCD_BLANK_LEADING_EN
    chk({name, "_blank"}, 32'(bus.blank), 32'(ek));
`else
    if (ek === 'x) $display("note: unknown blank expectation for %s", name);
`endif
    prev_bcd = eb;
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({name, "_busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    vec_t tbl[9];
    int   lat;
    int   ndone;
    logic [WIDTH-1:0] rv;

    tbl[0] = '{16'd0,     20'h00000, 1'b0, 5'b11110};
    tbl[1] = '{16'd1234,  20'h01234, 1'b0, 5'b10000};
    tbl[2] = '{16'd9999,  20'h09999, 1'b0, 5'b10000};
    tbl[3] = '{16'd10000, 20'h10000, 1'b1, 5'b00000};
    tbl[4] = '{16'd65535, 20'h65535, 1'b1, 5'b00000};
    tbl[5] = '{16'd10946, 20'h10946, 1'b1, 5'b00000};
    tbl[6] = '{16'd7,     20'h00007, 1'b0, 5'b11110};
    tbl[7] = '{16'd60000, 20'h60000, 1'b1, 5'b00000};
    tbl[8] = '{16'd42,    20'h00042, 1'b0, 5'b11100};

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.binary_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_bcd", 32'(bus.bcd_out), 32'd0);
    chk("rst_ovr", 32'(bus.over_range), 32'd0);
`ifdef BCD_BLANK_LEADING_EN
    chk("rst_blank", 32'(bus.blank), 32'd0);
`endif
    reset = 1'b0;

    foreach (tbl[i]) run_check($sformatf("tbl%0d", i), tbl[i].v, tbl[i].bcd, tbl[i].ovr, tbl[i].blk);

    for (int i = 0; i < 24; i++) begin
      rv = WIDTH'($urandom_range(0, 65535));
      run_check($sformatf("rnd%0d_%0d", i, rv), rv, ref_bcd(rv), ref_ovr(rv), ref_blank(rv));
    end

    // Start pulses while busy must be ignored; a start right after done is taken.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.binary_in = 16'd1234;
    ndone = 0;
    for (int k = 0; k < 30 && ndone == 0; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (k >= 2 && k < 6) begin
        bus.start     = 1'b1;
        bus.binary_in = 16'd5555;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("busy_ign_done", 32'(ndone), 32'd1);
    chk("busy_ign_bcd", 32'(bus.bcd_out), 32'h01234);
    prev_bcd = 20'h01234;
    convert(16'd5555, lat);
    chk("b2b_lat", 32'(lat), 32'(LAT));
    chk("b2b_bcd", 32'(bus.bcd_out), 32'h05555);
    chk("b2b_ovr", 32'(bus.over_range), 32'd0);
    prev_bcd = 20'h05555;
    @(negedge clk);

    // Reset in the middle of a conversion aborts it and clears the result.
    bus.start     = 1'b1;
    bus.binary_in = 16'd4321;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_bcd", 32'(bus.bcd_out), 32'd0);
    chk("midrst_ovr", 32'(bus.over_range), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    chk("midrst_bcd_held0", 32'(bus.bcd_out), 32'd0);
    prev_bcd = '0;
    run_check("after_rst42", 16'd42, 20'h00042, 1'b0, 5'b11100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
